// File: rtl/tiny8_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tiny8_mem_arbiter
// Brief    : Two-requester round-robin arbiter for the single tiny8 memory
//            port. Requester 0 is the core and requester 1 a secondary
//            master such as a loader or debug unit. Both use the
//            hold-until-resp protocol. A watchdog terminates grants that
//            memory never answers.
// Revision : 1.0 - initial release
// ============================================================================
module tiny8_mem_arbiter #(
    parameter int WORD_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    // requester 0 (tiny8v1 core)
    input  logic              r0_read,
    input  logic              r0_write,
    input  logic [WORD_W-1:0] r0_addr,
    input  logic [WORD_W-1:0] r0_wdata,
    output logic              r0_resp,
    output logic              r0_err,
    output logic [WORD_W-1:0] r0_rdata,
    // requester 1 (secondary master)
    input  logic              r1_read,
    input  logic              r1_write,
    input  logic [WORD_W-1:0] r1_addr,
    input  logic [WORD_W-1:0] r1_wdata,
    output logic              r1_resp,
    output logic              r1_err,
    output logic [WORD_W-1:0] r1_rdata,
    // memory port
    output logic              mem_read,
    output logic              mem_write,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_resp,
    input  logic [WORD_W-1:0] mem_rdata
);

    // Wait counter must hold 0..TIMEOUT-1; keep at least one bit so the
    // register exists even with the watchdog disabled.
    localparam int                 c_CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int                 c_TO_LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [c_CNT_W-1:0] c_TO_LAST   = c_TO_LAST_I[c_CNT_W-1:0];
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_GRANT0 = 2'd1;
    localparam logic [1:0] c_GRANT1 = 2'd2;

    logic [1:0]         r_state;
    logic               r_last;     // last requester that was served
    logic [c_CNT_W-1:0] r_cnt;      // grant cycles elapsed without mem_resp

    logic              w_req0;
    logic              w_req1;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_granted;
    logic              w_g_read;
    logic              w_g_write;
    logic              w_g_req;
    logic [WORD_W-1:0] w_g_addr;
    logic [WORD_W-1:0] w_g_wdata;
    logic              w_last_cycle;
    logic              w_expire;

    assign w_req0    = r0_read | r0_write;
    assign w_req1    = r1_read | r1_write;
    assign w_gnt0    = (r_state == c_GRANT0);
    assign w_gnt1    = (r_state == c_GRANT1);
    assign w_granted = w_gnt0 | w_gnt1;

    // Request of whichever master currently owns the port.
    assign w_g_read  = w_gnt1 ? r1_read  : r0_read;
    assign w_g_write = w_gnt1 ? r1_write : r0_write;
    assign w_g_addr  = w_gnt1 ? r1_addr  : r0_addr;
    assign w_g_wdata = w_gnt1 ? r1_wdata : r0_wdata;
    assign w_g_req   = w_g_read | w_g_write;

    // Final cycle the watchdog allows. It depends only on registered state,
    // so masking the strobes with it keeps mem_resp off the mem_* paths.
    // A mem_resp arriving in this cycle is still honoured as a completion.
    assign w_last_cycle = (TIMEOUT > 0) && w_granted && (r_cnt == c_TO_LAST);
    assign w_expire     = w_last_cycle & w_g_req & ~mem_resp;

    // Memory side: forwarded straight from the owner, zero while idle.
    // A read+write request is treated as a write.
    assign mem_write = w_granted & w_g_write & ~w_last_cycle;
    assign mem_read  = w_granted & w_g_read & ~w_g_write & ~w_last_cycle;
    assign mem_addr  = w_granted ? w_g_addr  : '0;
    assign mem_wdata = w_granted ? w_g_wdata : '0;

    // Requester side: resp/rdata pass through combinationally for the
    // core's single-cycle handshake; the waiting requester sees zeros.
    assign r0_resp  = w_gnt0 & (mem_resp | w_expire);
    assign r0_err   = w_gnt0 & w_expire;
    assign r0_rdata = (w_gnt0 & mem_resp) ? mem_rdata : '0;
    assign r1_resp  = w_gnt1 & (mem_resp | w_expire);
    assign r1_err   = w_gnt1 & w_expire;
    assign r1_rdata = (w_gnt1 & mem_resp) ? mem_rdata : '0;

    // Grant sequencing, round-robin memory and watchdog counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_last  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_cnt <= '0;
                    if (w_req0 && w_req1) begin
                        r_state <= r_last ? c_GRANT0 : c_GRANT1;
                    end else if (w_req0) begin
                        r_state <= c_GRANT0;
                    end else if (w_req1) begin
                        r_state <= c_GRANT1;
                    end
                end
                c_GRANT0, c_GRANT1: begin
                    if (mem_resp || w_expire) begin
                        r_state <= c_IDLE;
                        r_last  <= w_gnt1;
                        r_cnt   <= '0;
                    end else if (!w_g_req) begin
                        // owner walked away: release without touching fairness
                        r_state <= c_IDLE;
                        r_cnt   <= '0;
                    end else if (TIMEOUT > 0) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/tiny8_mem_arbiter.md
Name: tiny8_mem_arbiter

Overview:
Two-requester arbiter for the single tiny8 memory port. Requester 0 is the tiny8v1 core; requester 1 is a secondary master such as a program loader or debug unit. Both requesters use the core's hold-until-resp read/write protocol. The block grants one requester at a time with round-robin fairness and forwards its request to memory. It has a watchdog that terminates transactions the memory never answers.

Parameters:
WORD_W, 8, width of address and data words (matches tiny8_word)
TIMEOUT, 64, cycles in a grant without mem_resp before forced termination; 0 disables the watchdog

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
r0_read  input  1  requester 0 read request
r0_write  input  1  requester 0 write request
r0_addr  input  WORD_W  requester 0 address
r0_wdata  input  WORD_W  requester 0 write data
r0_resp  output  1  requester 0 transaction complete (1-cycle pulse)
r0_err  output  1  requester 0 transaction timed out (with r0_resp)
r0_rdata  output  WORD_W  requester 0 read data
r1_read, r1_write, r1_addr, r1_wdata, r1_resp, r1_err, r1_rdata: same as r0_*, for requester 1
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_addr  output  WORD_W  memory address
mem_wdata  output  WORD_W  memory write data
mem_resp  input  1  memory completion
mem_rdata  input  WORD_W  memory read data

Behaviour:
- Registered state: fsm {IDLE, GRANT0, GRANT1}, last (1 bit, last served requester), wait counter (width clog2(TIMEOUT+1), min 1).
- Reset: fsm=IDLE, last=1 (so r0 wins the first tie), counter=0. All outputs are 0 while in IDLE, so every output is 0 from the first edge with rst high. mem_resp is ignored while in IDLE.
- Request means rN_read | rN_write.
- In IDLE:
  - Only one requester requesting: go to its GRANT state.
  - Both requesting: go to GRANT of the requester != last.
  - None: stay in IDLE.
  - Decision is made at the edge, so the first mem strobe appears 1 cycle after the request is first seen.
- In GRANTn:
  - mem_addr and mem_wdata are taken combinationally from rn.
  - mem_write = rn_write.
  - mem_read = rn_read & ~rn_write. If a requester asserts both, the write wins and the read is masked.
  - The other requester sees resp=0, err=0, rdata=0 and is stalled.
- Completion: mem_resp=1 in GRANTn gives, in the same cycle, rn_resp=1 and rn_rdata=mem_rdata. The next state is IDLE, with last=n and counter=0.
- rN_rdata is 0 whenever rN_resp=0.
- Abandon: if the granted requester drops both read and write before mem_resp, go to IDLE next cycle with no resp and last unchanged. mem strobes follow the inputs, so they are already low in that cycle.
- Watchdog (TIMEOUT>0):
  - The counter increments each GRANT cycle without mem_resp.
  - When the counter equals TIMEOUT-1 and mem_resp=0: rn_resp=1, rn_err=1, rn_rdata=0, and mem_read/mem_write are forced to 0 in that cycle. Next state is IDLE, last=n.
  - mem_resp on the timeout cycle counts as normal completion (err=0).
- Back-to-back: there is always ≥1 IDLE cycle between grants. A requester still asserting in the cycle after its resp is seen as a new request in IDLE.
- Reset mid-transaction: at the edge with rst=1 the fsm goes to IDLE and strobes drop. The requester receives no resp. A later mem_resp is ignored.
- Timing: no combinational path from mem_resp to mem_* outputs. The mem_resp → rN_resp/rN_rdata path is combinational, matching the core's 1-cycle handshake.

Test Plan:
- Single read: r0_read=1, r0_addr=8'h10; memory answers 3 cycles later with mem_rdata=8'hA5 → mem_read high from cycle 1 with mem_addr=8'h10; r0_resp pulse with r0_rdata=8'hA5; fsm back to IDLE.
- Contention fairness: r0 and r1 both request reads continuously after reset, memory 1-cycle latency → grant order r0,r1,r0,r1; each resp pulses once per grant; mem_read never carries the wrong addr.
- Write while other waits: r1_write=1, addr 8'h20, wdata 8'h3C granted; r0_read arrives mid-grant → r0 stalled (r0_resp=0) until r1_resp, then r0 granted after 1 IDLE cycle; mem_wdata=8'h3C only during r1 grant.
- Timeout: TIMEOUT=4, r0_read, mem_resp held 0 → r0_resp=1, r0_err=1, r0_rdata=0 on the 4th grant cycle; mem_read=0 that cycle; next request is served normally.
- Reset mid-transaction: r1 granted, rst pulsed 1 cycle before mem_resp → all outputs 0 after the edge, no r1_resp, fsm IDLE, last=1 (r0 wins next tie).
- Abandon and illegal both-strobes: r0 asserts read+write at addr 8'h05 → only mem_write=1. r0 then drops both before resp → IDLE next cycle with no resp; a pending r1 is granted next.
